// File: rtl/renesas_cfg_seq_if.sv
// Command/response handshake between the config sequencer and the I2C byte master.
interface renesas_cfg_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_dev;
   logic [7:0] cmd_reg;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_nack;

   modport master (
      output cmd_valid, cmd_dev, cmd_reg, cmd_data,
      input  cmd_ready, rsp_valid, rsp_nack
   );

   modport slave (
      input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
      output cmd_ready, rsp_valid, rsp_nack
   );
endinterface

// File: rtl/renesas_cfg_seq.sv
// Replays 2-word config records from BRAM port B as I2C register writes.
// Optional NACK retry is enabled by defining RENESAS_SEQ_RETRY_EN.
module renesas_cfg_seq #(
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned DLY_TICK  = 1000,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic              sys_if_clk,
   input  logic              sys_if_rstn,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       base_addr,
   input  logic [6:0]        dev_addr,
   output logic              i2c_web,
   output logic [15:0]       i2c_addrb,
   output logic [15:0]       i2c_dinb,
   input  logic [15:0]       i2c_doutb,
   renesas_cfg_seq_if.master cmd_if,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [15:0]       err_addr,
   output logic [15:0]       wr_count
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH0 = 4'd1;
   localparam logic [3:0] S_FETCH1 = 4'd2;
   localparam logic [3:0] S_DECODE = 4'd3;
   localparam logic [3:0] S_CMD    = 4'd4;
   localparam logic [3:0] S_RSP    = 4'd5;
   localparam logic [3:0] S_DLY    = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;
   localparam logic [3:0] S_ERR    = 4'd8;

   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1) + 1;
`ifdef RENESAS_SEQ_RETRY_EN
   localparam int unsigned RETRY_LIM = MAX_RETRY;
`else
   localparam int unsigned RETRY_LIM = 0;
`endif
   localparam logic [RETRY_W-1:0] RETRY_LIM_W = RETRY_W'(RETRY_LIM);
   localparam logic [1:0]         LAT_MAX     = 2'(RD_LAT);
   localparam logic [31:0]        TICK_W      = 32'(DLY_TICK);

   logic [3:0]         state_q, state_d;
   logic [1:0]         lat_q, lat_d;
   logic [15:0]        ptr_q, ptr_d;
   logic [15:0]        w0_q, w0_d;
   logic [31:0]        dly_q, dly_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [1:0]         pcode_q, pcode_d;
   logic [15:0]        addrb_q, addrb_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic [6:0]         dev_q, dev_d;
   logic [7:0]         reg_q, reg_d;
   logic [7:0]         data_q, data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [1:0]         code_q, code_d;
   logic [15:0]        eaddr_q, eaddr_d;
   logic [15:0]        wr_q, wr_d;
   logic               adv;

   assign i2c_web          = 1'b0;
   assign i2c_dinb         = 16'h0000;
   assign i2c_addrb        = addrb_q;
   assign cmd_if.cmd_valid = cmd_valid_q;
   assign cmd_if.cmd_dev   = dev_q;
   assign cmd_if.cmd_reg   = reg_q;
   assign cmd_if.cmd_data  = data_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
   assign err_code         = code_q;
   assign err_addr         = eaddr_q;
   assign wr_count         = wr_q;

   // Next-state and output decode; abort takes priority over every non-IDLE state
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      ptr_d       = ptr_q;
      w0_d        = w0_q;
      dly_d       = dly_q;
      retry_d     = retry_q;
      pcode_d     = pcode_q;
      addrb_d     = addrb_q;
      cmd_valid_d = cmd_valid_q;
      dev_d       = dev_q;
      reg_d       = reg_q;
      data_d      = data_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      code_d      = code_q;
      eaddr_d     = eaddr_q;
      wr_d        = wr_q;
      adv         = 1'b0;

      if (state_q != S_IDLE && abort) begin
         state_d     = S_IDLE;
         cmd_valid_d = 1'b0;
         busy_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               state_d = S_FETCH0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               code_d  = 2'b00;
               eaddr_d = 16'h0000;
               wr_d    = 16'h0000;
               ptr_d   = base_addr;
               addrb_d = base_addr;
               lat_d   = 2'd0;
               retry_d = '0;
            end
            S_FETCH0: if (lat_q == LAT_MAX) begin
               w0_d    = i2c_doutb;
               addrb_d = ptr_q + 16'd1;
               lat_d   = 2'd0;
               state_d = S_FETCH1;
            end else begin
               lat_d = lat_q + 2'd1;
            end
            S_FETCH1: if (lat_q == LAT_MAX) begin
               data_d  = i2c_doutb[7:0];
               state_d = S_DECODE;
            end else begin
               lat_d = lat_q + 2'd1;
            end
            S_DECODE: case (w0_q[15:14])
               2'b00: state_d = S_DONE;
               2'b01: begin
                  dev_d       = dev_addr;
                  reg_d       = w0_q[7:0];
                  cmd_valid_d = 1'b1;
                  state_d     = S_CMD;
               end
               2'b10: if (w0_q[13:0] == 14'd0) begin
                  adv = 1'b1;
               end else begin
                  dly_d   = 32'(w0_q[13:0]) * TICK_W;
                  state_d = S_DLY;
               end
               default: begin
                  pcode_d = 2'b10;
                  state_d = S_ERR;
               end
            endcase
            S_CMD: if (cmd_if.cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = S_RSP;
            end
            S_RSP: if (cmd_if.rsp_valid) begin
               if (!cmd_if.rsp_nack) begin
                  if (wr_q != 16'hFFFF) wr_d = wr_q + 16'd1;
                  adv = 1'b1;
               end else if (retry_q != RETRY_LIM_W) begin
                  retry_d     = retry_q + RETRY_W'(1);
                  cmd_valid_d = 1'b1;
                  state_d     = S_CMD;
               end else begin
                  pcode_d = 2'b01;
                  state_d = S_ERR;
               end
            end
            S_DLY: if (dly_q <= 32'd1) begin
               adv = 1'b1;
            end else begin
               dly_d = dly_q - 32'd1;
            end
            S_DONE: begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            S_ERR: begin
               err_d   = 1'b1;
               code_d  = pcode_q;
               eaddr_d = ptr_q;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         // Step to the next record unless its word1 would wrap past 16'hFFFF
         if (adv) begin
            if (ptr_q >= 16'hFFFE) begin
               pcode_d = 2'b11;
               state_d = S_ERR;
            end else begin
               ptr_d   = ptr_q + 16'd2;
               addrb_d = ptr_q + 16'd2;
               lat_d   = 2'd0;
               retry_d = '0;
               state_d = S_FETCH0;
            end
         end
      end
   end

   always_ff @(posedge sys_if_clk) begin
      if (!sys_if_rstn) begin
         state_q     <= S_IDLE;
         lat_q       <= 2'd0;
         ptr_q       <= 16'h0000;
         w0_q        <= 16'h0000;
         dly_q       <= 32'd0;
         retry_q     <= '0;
         pcode_q     <= 2'b00;
         addrb_q     <= 16'h0000;
         cmd_valid_q <= 1'b0;
         dev_q       <= 7'h00;
         reg_q       <= 8'h00;
         data_q      <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         code_q      <= 2'b00;
         eaddr_q     <= 16'h0000;
         wr_q        <= 16'h0000;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         ptr_q       <= ptr_d;
         w0_q        <= w0_d;
         dly_q       <= dly_d;
         retry_q     <= retry_d;
         pcode_q     <= pcode_d;
         addrb_q     <= addrb_d;
         cmd_valid_q <= cmd_valid_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         code_q      <= code_d;
         eaddr_q     <= eaddr_d;
         wr_q        <= wr_d;
      end
   end

endmodule

// File: tb/tb_renesas_cfg_seq.sv
// Scoreboard bench: BRAM model with RD_LAT pipeline plus an I2C master responder.
module tb_renesas_cfg_seq;
   localparam int unsigned RD_LAT    = 2;
   localparam int unsigned DLY_TICK  = 10;
   localparam int unsigned MAX_RETRY = 3;
   localparam logic [6:0]  DEV       = 7'h5C;
`ifdef RENESAS_SEQ_RETRY_EN
   localparam int N_ATT = MAX_RETRY + 1;
`else
   localparam int N_ATT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] base_addr = 16'h0000;
   logic [6:0]  dev_addr = DEV;
   logic        i2c_web;
   logic [15:0] i2c_addrb, i2c_dinb, i2c_doutb;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [15:0] err_addr, wr_count;

   renesas_cfg_seq_if bus ();

   renesas_cfg_seq #(.RD_LAT(RD_LAT), .DLY_TICK(DLY_TICK), .MAX_RETRY(MAX_RETRY)) dut (
      .sys_if_clk(clk), .sys_if_rstn(rst_n), .start(start), .abort(abort),
      .base_addr(base_addr), .dev_addr(dev_addr), .i2c_web(i2c_web),
      .i2c_addrb(i2c_addrb), .i2c_dinb(i2c_dinb), .i2c_doutb(i2c_doutb),
      .cmd_if(bus), .busy(busy), .done(done), .err(err), .err_code(err_code),
      .err_addr(err_addr), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   // BRAM port B: address registered, data out RD_LAT cycles later
   logic [15:0] mem [0:65535];
   logic [15:0] pipe [RD_LAT];
   always @(posedge clk) begin
      pipe[0] <= mem[i2c_addrb];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign i2c_doutb = pipe[RD_LAT-1];

   int n_tests = 0;
   int n_fail  = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [22:0] sb_q[$];
   logic [22:0] cap;
   bit          ready_en  = 1'b1;
   int          rsp_dly   = 2;
   int          nack_from = 0;
   int          n_acc     = 0;
   int          mstate    = 0;
   int          wcnt      = 0;
   bit          nack_pend = 1'b0;

   // I2C master responder; pops the scoreboard on each accepted command
   initial begin
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
      forever begin
         @(negedge clk);
         bus.rsp_valid = 1'b0;
         bus.rsp_nack  = 1'b0;
         case (mstate)
            0: if (bus.cmd_valid && ready_en) begin
               bus.cmd_ready = 1'b1;
               cap = {bus.cmd_dev, bus.cmd_reg, bus.cmd_data};
               mstate = 1;
            end
            1: begin
               bus.cmd_ready = 1'b0;
               n_acc++;
               if (sb_q.size() == 0) chk("sb_unexpected_cmd", 32'(cap), 32'h7FFFFFFF);
               else chk("cmd_fields", 32'(cap), 32'(sb_q.pop_front()));
               wcnt = rsp_dly;
               nack_pend = (nack_from != 0) && (n_acc >= nack_from);
               mstate = 2;
            end
            default: if (wcnt == 0) begin
               bus.rsp_valid = 1'b1;
               bus.rsp_nack  = nack_pend;
               mstate = 0;
            end else begin
               wcnt--;
            end
         endcase
      end
   end

   task automatic put(input int a, input logic [15:0] w0, input logic [15:0] w1);
      mem[16'(a)]     = w0;
      mem[16'(a + 1)] = w1;
   endtask

   task automatic clr();
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
   endtask

   task automatic kick(input logic [15:0] base);
      @(negedge clk);
      base_addr = base;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, 32'(busy), 0);
   endtask

   task automatic basic_tbl();
      clr();
      put(0, 16'h4012, 16'h00A5);
      put(2, 16'h4013, 16'h005A);
      put(4, 16'h0000, 16'h0000);
   endtask

   initial begin
      int lat, bad, t21, t22, cyc, cv, gap, n;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_flags", 32'({busy, done, err, err_code, bus.cmd_valid, i2c_web}), 0);
      chk("rst_addrb", 32'(i2c_addrb), 0);
      chk("rst_dinb", 32'(i2c_dinb), 0);
      chk("rst_wr_count", 32'(wr_count), 0);
      chk("rst_err_addr", 32'(err_addr), 0);
      rst_n = 1'b1;

      // Two writes then END; also first-command latency
      basic_tbl();
      sb_q.push_back({DEV, 8'h12, 8'hA5});
      sb_q.push_back({DEV, 8'h13, 8'h5A});
      n_acc = 0;
      kick(16'h0000);
      lat = 0;
      while (!bus.cmd_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("first_cmd_lat", 32'(lat), 32'(2 * (RD_LAT + 1) + 1));
      wait_idle("basic");
      chk("basic_done", 32'(done), 1);
      chk("basic_err", 32'(err), 0);
      chk("basic_wr_count", 32'(wr_count), 2);
      chk("basic_n_acc", 32'(n_acc), 2);

      // Reset mid-fetch: outputs cleared, no further fetching
      kick(16'h0000);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_flags", 32'({busy, done, err, bus.cmd_valid}), 0);
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy || bus.cmd_valid || i2c_addrb != 16'h0000) bad++;
      end
      chk("midrst_quiet", 32'(bad), 0);

      // cmd_ready held low: fields stable, a start while busy ignored
      clr();
      put(0, 16'h4031, 16'h00C7);
      sb_q.push_back({DEV, 8'h31, 8'hC7});
      ready_en = 1'b0;
      n_acc = 0;
      kick(16'h0000);
      n = 0;
      while (!bus.cmd_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("stall_cmd_seen", 32'(bus.cmd_valid), 1);
      chk("stall_first_fields", 32'({bus.cmd_dev, bus.cmd_reg, bus.cmd_data}), 32'({DEV, 8'h31, 8'hC7}));
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) begin
            base_addr = 16'h0020;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (!bus.cmd_valid || {bus.cmd_dev, bus.cmd_reg, bus.cmd_data} != {DEV, 8'h31, 8'hC7}) bad++;
      end
      chk("stall_stable", 32'(bad), 0);
      ready_en = 1'b1;
      wait_idle("stall");
      chk("stall_n_acc", 32'(n_acc), 1);
      chk("stall_wr_count", 32'(wr_count), 1);
      chk("stall_done", 32'(done), 1);

      // DELAY 3 units then END
      put(16'h20, 16'h8003, 16'h0000);
      put(16'h22, 16'h0000, 16'h0000);
      kick(16'h0020);
      t21 = -1; t22 = -1; cyc = 0; cv = 0;
      while (busy && cyc < 2000) begin
         if (i2c_addrb == 16'h0021 && t21 < 0) t21 = cyc;
         if (i2c_addrb == 16'h0022 && t22 < 0) t22 = cyc;
         if (bus.cmd_valid) cv++;
         @(negedge clk);
         cyc++;
      end
      gap = t22 - t21 - int'(RD_LAT + 1);
      chk($sformatf("dly_gap_in_29_31(gap=%0d)", gap), 32'(gap >= 29 && gap <= 31), 1);
      chk("dly_no_cmd", 32'(cv), 0);
      chk("dly_done", 32'(done), 1);
      chk("dly_wr_count", 32'(wr_count), 0);

      // NACK on the second of three writes
      clr();
      put(0, 16'h4012, 16'h00A5);
      put(2, 16'h4013, 16'h005A);
      put(4, 16'h4014, 16'h00C3);
      sb_q.push_back({DEV, 8'h12, 8'hA5});
      for (int i = 0; i < N_ATT; i++) sb_q.push_back({DEV, 8'h13, 8'h5A});
      n_acc = 0;
      nack_from = 2;
      kick(16'h0000);
      wait_idle("nack");
      nack_from = 0;
      chk("nack_err", 32'(err), 1);
      chk("nack_code", 32'(err_code), 1);
      chk("nack_err_addr", 32'(err_addr), 2);
      chk("nack_wr_count", 32'(wr_count), 1);
      chk("nack_attempts", 32'(n_acc), 32'(1 + N_ATT));
      chk("nack_done", 32'(done), 0);

      // Bad opcode at address 4
      basic_tbl();
      put(4, 16'hC000, 16'h0000);
      sb_q.push_back({DEV, 8'h12, 8'hA5});
      sb_q.push_back({DEV, 8'h13, 8'h5A});
      kick(16'h0000);
      wait_idle("badop");
      chk("badop_code", 32'(err_code), 2);
      chk("badop_err_addr", 32'(err_addr), 4);
      chk("badop_wr_count", 32'(wr_count), 2);

      // Record at 16'hFFFE: one write, then address-wrap error
      put(16'hFFFE, 16'h4021, 16'h0077);
      sb_q.push_back({DEV, 8'h21, 8'h77});
      kick(16'hFFFE);
      wait_idle("wrap");
      chk("wrap_err", 32'(err), 1);
      chk("wrap_code", 32'(err_code), 3);
      chk("wrap_err_addr", 32'(err_addr), 32'h0000FFFE);
      chk("wrap_wr_count", 32'(wr_count), 1);

      // Abort while waiting for a response; the late response is ignored
      basic_tbl();
      sb_q.push_back({DEV, 8'h12, 8'hA5});
      rsp_dly = 15;
      n_acc = 0;
      kick(16'h0000);
      n = 0;
      while (!(n_acc == 1 && mstate == 2) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort_in_rsp", 32'(mstate), 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_cmd_valid", 32'(bus.cmd_valid), 0);
      chk("abort_flags", 32'({done, err}), 0);
      n = 0;
      while (mstate != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("late_rsp_busy", 32'(busy), 0);
      chk("late_rsp_wr_count", 32'(wr_count), 0);

      // Re-run after abort
      rsp_dly = 2;
      sb_q.push_back({DEV, 8'h12, 8'hA5});
      sb_q.push_back({DEV, 8'h13, 8'h5A});
      n_acc = 0;
      kick(16'h0000);
      wait_idle("rerun");
      chk("rerun_done", 32'(done), 1);
      chk("rerun_wr_count", 32'(wr_count), 2);
      chk("rerun_n_acc", 32'(n_acc), 2);
      chk("sb_empty", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule

// File: doc/renesas_cfg_seq.md
Name: renesas_cfg_seq

Overview:
- Reader end of the Renesas config BRAM: fetches 16-bit config records from BRAM port B and replays them as I2C register writes through a command/response handshake to the I2C byte master.
- Sits between the BRAM port B (i2c_* signals) and the I2C master.
- Software loads the table through port A, sets the base address and pulses start; the block reports busy/done/error status back to the system interface.

Parameters:
- RD_LAT, 1, BRAM port B read latency in cycles (legal 1..3).
- DLY_TICK, 1000, clock cycles per DELAY record unit.
- MAX_RETRY, 3, NACK retries per write (used only with the optional feature).

Ports:
- sys_if_clk  in  1  clock, also drives BRAM port B.
- sys_if_rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begin sequencing at base_addr.
- abort  in  1  one-cycle pulse; stop and return to IDLE.
- base_addr  in  16  word address of the first record.
- dev_addr  in  7  I2C 7-bit device address for all writes.
- i2c_web  out  1  BRAM port B write enable; always 0.
- i2c_addrb  out  16  BRAM port B word address.
- i2c_dinb  out  16  BRAM port B write data; always 0.
- i2c_doutb  in  16  BRAM port B read data.
- cmd_valid  out  1  write command valid.
- cmd_ready  in  1  master accepts the command.
- cmd_dev  out  7  device address.
- cmd_reg  out  8  register offset.
- cmd_data  out  8  data byte.
- rsp_valid  in  1  one-cycle pulse; write finished.
- rsp_nack  in  1  qualified by rsp_valid; 1 = NACK.
- busy  out  1  sequencing in progress.
- done  out  1  sticky; END record reached.
- err  out  1  sticky; error stop.
- err_code  out  2  error cause: 01 NACK, 10 bad opcode, 11 address wrap.
- err_addr  out  16  word0 address of the failing record.
- wr_count  out  16  writes acknowledged since start.

Behaviour:
- Reset: all outputs 0 and state IDLE; i2c_web and i2c_dinb are tied 0.
- Record format: two 16-bit words at addresses A and A+1.
  - word0[15:14] is the opcode: 00 END, 01 WRITE, 10 DELAY, 11 bad.
  - WRITE: cmd_reg = word0[7:0], cmd_data = word1[7:0].
  - DELAY: wait word0[13:0] × DLY_TICK cycles; a count of 0 waits 0 cycles; word1 is fetched and ignored.
- States:
  - IDLE -> FETCH0 on start. Actions: busy=1; done, err, err_code, err_addr, wr_count cleared; ptr = base_addr.
  - FETCH0: drive i2c_addrb = ptr; wait RD_LAT cycles; latch word0.
  - FETCH1: drive i2c_addrb = ptr+1; wait RD_LAT cycles; latch word1.
  - DECODE:
    - END -> DONE.
    - WRITE -> CMD.
    - DELAY -> DLY.
    - 11 -> ERR with code 10.
  - CMD: hold cmd_valid and fields stable until cmd_ready is sampled 1, then -> RSP.
  - RSP: wait for rsp_valid.
    - ACK: wr_count++, advance.
    - NACK: -> ERR with code 01.
  - DLY: down-count to 0, then advance.
  - Advance:
    - If ptr ≥ 16'hFFFE (next record would wrap): -> ERR with code 11.
    - Otherwise ptr += 2 and -> FETCH0.
  - DONE: done=1, busy=0 -> IDLE.
  - ERR: err=1, err_addr = ptr, busy=0 -> IDLE.
- Minimum per-record overhead: 2×(RD_LAT+1)+1 cycles before cmd_valid rises.
- start while busy is ignored.
- abort in any non-IDLE state: -> IDLE next cycle; cmd_valid=0, busy=0; done/err unchanged.
  - An abort in RSP discards any later rsp_valid.
- abort and start in the same IDLE cycle: start wins.
- rsp_valid arriving outside RSP is ignored.
- Reset mid-operation returns the block to the reset state with no further BRAM reads.
- wr_count saturates at 16'hFFFF.

Optional Feature:
- Macro RENESAS_SEQ_RETRY_EN.
- Defined: a NACK re-enters CMD with the same fields, up to MAX_RETRY times per record. The retry counter clears on each new record. After MAX_RETRY+1 NACKs the block goes to ERR with code 01.
- Undefined: the first NACK goes to ERR; MAX_RETRY is unused.

Test Plan:
- BRAM image {0x4012,0x00A5, 0x4013,0x005A, 0x0000,0x0000}, base 0, start, master ACKs -> commands (dev,0x12,0xA5) then (dev,0x13,0x5A); done=1; wr_count=2; err=0.
- DELAY record 0x8003 with DLY_TICK=10 followed by END -> 30 cycles (±1) between the word1 fetch and the END fetch; no cmd_valid.
- cmd_ready held 0 for 50 cycles -> cmd_valid and fields stay stable; exactly one command is accepted when ready rises.
- NACK on the second WRITE of a 3-write table:
  - feature undefined -> err=1, err_code=01, err_addr=2, wr_count=1.
  - feature defined with MAX_RETRY=3 -> 4 attempts, then the same error.
- Bad opcode 0xC000 at address 4 -> err_code=10, err_addr=4. Separately, base_addr=0xFFFE with a WRITE record -> one write, then err_code=11.
- abort during RSP, then a late rsp_valid -> IDLE with busy=0 and wr_count unchanged. A subsequent start re-runs the table cleanly.
